// File: rtl/enc_8b10b.sv
// ---------------------------------------------------------------------------
// enc_8b10b -- pipelined 8b/10b line encoder (transmit side).
//
// Encodes one byte plus a control flag per cycle into a 10-bit symbol while
// tracking running disparity (RD) internally. Latency is two cycles and
// throughput is one symbol per cycle. There is no backpressure.
//
// Ports:
//   clk        in   1  single clock, rising edge
//   reset      in   1  synchronous, active-high; clears pipeline, RD := -1
//   din        in   8  byte, din[4:0] = EDCBA (x), din[7:5] = HGF (y)
//   kin        in   1  1 = encode din as control symbol K.x.y
//   din_valid  in   1  qualifies din/kin this cycle
//   dout       out 10  symbol, dout[9:4] = abcdei (a at bit 9),
//                      dout[3:0] = fghj (f at bit 3)
//   dout_valid out  1  dout carries an encoded input byte
//   rdispout   out  1  RD after dout (0 = -1, 1 = +1)
//   kerr       out  1  kin = 1 with a byte that is not a legal K code;
//                      that byte is then sent as data D.x.y
//
// Build option:
//   ENC_IDLE_COMMA_EN  when defined, cycles without din_valid emit K28.5 at
//                      the current RD (dout_valid = 0) and RD advances, so
//                      the link keeps seeing commas. When undefined, such
//                      cycles hold dout/rdispout and leave RD untouched.
// ---------------------------------------------------------------------------
module enc_8b10b (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       kin,
    input  logic       din_valid,
    output logic [9:0] dout,
    output logic       dout_valid,
    output logic       rdispout,
    output logic       kerr
);

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // Legal control codes: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7.
    function automatic logic is_legal_k(input logic [7:0] b);
        logic [4:0] x;
        logic [2:0] y;
        x = b[4:0];
        y = b[7:5];
        return (x == 5'd28) ||
               ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) ||
                                (x == 5'd29) || (x == 5'd30)));
    endfunction

    function automatic logic [2:0] ones6(input logic [5:0] c);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 6; i++) begin
            n = n + {2'b00, c[i]};
        end
        return n;
    endfunction

    function automatic logic [2:0] ones4(input logic [3:0] c);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, c[i]};
        end
        return n;
    endfunction

    // 5b/6b sub-block. The table holds the RD- column; the RD+ column is
    // its complement for unbalanced entries. D.7 is the one balanced code
    // whose RD+ form differs (111000 / 000111).
    function automatic logic [5:0] enc_5b6b(input logic [4:0] x,
                                            input logic       k28,
                                            input logic       rd);
        logic [5:0] c;
        if (k28) begin
            c = 6'b001111;
        end else begin
            case (x)
                5'd1:    c = 6'b011101;
                5'd2:    c = 6'b101101;
                5'd3:    c = 6'b110001;
                5'd4:    c = 6'b110101;
                5'd5:    c = 6'b101001;
                5'd6:    c = 6'b011001;
                5'd7:    c = 6'b111000;
                5'd8:    c = 6'b111001;
                5'd9:    c = 6'b100101;
                5'd10:   c = 6'b010101;
                5'd11:   c = 6'b110100;
                5'd12:   c = 6'b001101;
                5'd13:   c = 6'b101100;
                5'd14:   c = 6'b011100;
                5'd15:   c = 6'b010111;
                5'd16:   c = 6'b011011;
                5'd17:   c = 6'b100011;
                5'd18:   c = 6'b010011;
                5'd19:   c = 6'b110010;
                5'd20:   c = 6'b001011;
                5'd21:   c = 6'b101010;
                5'd22:   c = 6'b011010;
                5'd23:   c = 6'b111010;
                5'd24:   c = 6'b110011;
                5'd25:   c = 6'b100110;
                5'd26:   c = 6'b010110;
                5'd27:   c = 6'b110110;
                5'd28:   c = 6'b001110;
                5'd29:   c = 6'b101110;
                5'd30:   c = 6'b011110;
                5'd31:   c = 6'b101011;
                default: c = 6'b100111;
            endcase
        end
        if (rd) begin
            if (!k28 && (x == 5'd7)) begin
                c = 6'b000111;
            end else if (ones6(c) != 3'd3) begin
                c = ~c;
            end
        end
        return c;
    endfunction

    // 3b/4b sub-block, RD- column stored. Under RD+ the code is complemented
    // when unbalanced, for D.x.3 (1100/0011), and for every K28 entry
    // (which covers the balanced K28.1/.5/.6 complements).
    function automatic logic [3:0] enc_3b4b(input logic [2:0] y,
                                            input logic       ktab,
                                            input logic       alt7,
                                            input logic       rd);
        logic [3:0] c;
        if (ktab) begin
            case (y)
                3'd1:    c = 4'b0110;
                3'd2:    c = 4'b1010;
                3'd3:    c = 4'b1100;
                3'd4:    c = 4'b1101;
                3'd5:    c = 4'b0101;
                3'd6:    c = 4'b1001;
                3'd7:    c = 4'b0111;
                default: c = 4'b1011;
            endcase
        end else begin
            case (y)
                3'd1:    c = 4'b1001;
                3'd2:    c = 4'b0101;
                3'd3:    c = 4'b1100;
                3'd4:    c = 4'b1101;
                3'd5:    c = 4'b1010;
                3'd6:    c = 4'b0110;
                3'd7:    c = alt7 ? 4'b0111 : 4'b1110;
                default: c = 4'b1011;
            endcase
        end
        if (rd && (ktab || (y == 3'd3) || (ones4(c) != 3'd2))) begin
            c = ~c;
        end
        return c;
    endfunction

    // -----------------------------------------------------------------------
    // Stage 1: capture input, classify K legality
    // -----------------------------------------------------------------------
    logic       vld_p1;
    logic [7:0] din_p1;
    logic       kok_p1;
    logic       kerr_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= din_valid;
        end
    end

    always_ff @(posedge clk) begin
        din_p1  <= din;
        kok_p1  <= kin & is_legal_k(din);
        kerr_p1 <= kin & ~is_legal_k(din);
    end

    // -----------------------------------------------------------------------
    // Stage 2: sub-block lookup against the live RD register
    // -----------------------------------------------------------------------
    logic       rd_p2;
    logic [4:0] sym_x;
    logic [2:0] sym_y;
    logic       sym_k;
    logic       k28;
    logic       alt7;
    logic       rd_mid;
    logic       rd_nxt;
    logic [5:0] code6;
    logic [3:0] code4;

    always_comb begin
        sym_x = din_p1[4:0];
        sym_y = din_p1[7:5];
        sym_k = kok_p1;
`ifdef ENC_IDLE_COMMA_EN
        if (!vld_p1) begin
            sym_x = 5'd28;
            sym_y = 3'd5;
            sym_k = 1'b1;
        end
`endif
        k28    = sym_k && (sym_x == 5'd28);
        code6  = enc_5b6b(sym_x, k28, rd_p2);
        rd_mid = rd_p2 ^ (ones6(code6) != 3'd3);
        // A7 avoids a run of five equal bits across the 6b/4b boundary;
        // control codes always take the 0111/1000 form.
        alt7   = sym_k ||
                 (!rd_mid && ((sym_x == 5'd17) || (sym_x == 5'd18) || (sym_x == 5'd20))) ||
                 ( rd_mid && ((sym_x == 5'd11) || (sym_x == 5'd13) || (sym_x == 5'd14)));
        code4  = enc_3b4b(sym_y, k28, alt7, rd_mid);
        rd_nxt = rd_mid ^ (ones4(code4) != 3'd2);
    end

    // RD is fed straight back into the lookup above, so back-to-back
    // symbols chain without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            kerr       <= 1'b0;
            rd_p2      <= 1'b0;
        end else begin
            dout_valid <= vld_p1;
            kerr       <= vld_p1 & kerr_p1;
`ifdef ENC_IDLE_COMMA_EN
            dout       <= {code6, code4};
            rd_p2      <= rd_nxt;
`else
            if (vld_p1) begin
                dout  <= {code6, code4};
                rd_p2 <= rd_nxt;
            end
`endif
        end
    end

    assign rdispout = rd_p2;

endmodule
